sram_rd_pipe: RTL and testbench
===============================

SRAM_RD_PIPE -- requirements
Module: sram_rd_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, SRAM word and R data width; legal values 32/64/128.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have parameter SRAM_AW, default 12, SRAM word address width (2^SRAM_AW words).
REQ-005 SHALL have parameter DEPTH, default 3, return buffer entries; legal range 2..8.
REQ-006 aclk_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 areset_i  in  1  reset, synchronous, active-high.
REQ-008 addr_i  in  ADDR_WIDTH  per-beat byte address from the upstream address sequencer.
REQ-009 addr_last_i  in  1  marks final beat of the burst.
REQ-010 addr_valid_i  in  1  beat request valid.
REQ-011 addr_ready_o  out  1  beat accepted when high together with addr_valid_i.
REQ-012 id_i  in  ID_WIDTH  burst ID; held stable by upstream for the whole burst.
REQ-013 sram_en_o  out  1  SRAM read enable.
REQ-014 sram_addr_o  out  SRAM_AW  SRAM word address.
REQ-015 sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid exactly one cycle after sram_en_o.
REQ-016 rid_o  out  ID_WIDTH  AXI R ID.
REQ-017 rdata_o  out  DATA_WIDTH  AXI R data.
REQ-018 rresp_o  out  2  AXI R response.
REQ-019 rlast_o  out  1  AXI R last.
REQ-020 rvalid_o  out  1  AXI R valid.
REQ-021 rready_i  in  1  AXI R ready.

Function
REQ-022 Beat handshake = addr_valid_i & addr_ready_o; addr_ready_o SHALL be (count + inflight) < DEPTH, from registers only (no combinational path from rready_i or addr_valid_i).
REQ-023 count = buffer occupancy 0..DEPTH; inflight = 1-bit flag set in the cycle after a handshake, cleared otherwise.
REQ-024 Word offset OFT = log2(DATA_WIDTH/8); sram_addr_o SHALL be addr_i[OFT+SRAM_AW-1:OFT] combinationally; sram_en_o = handshake & in_range.
REQ-025 in_range SHALL be true when addr_i[ADDR_WIDTH-1:OFT+SRAM_AW] is all zero; low OFT bits ignored (narrow transfers return the full word).
REQ-026 At handshake SHALL register {id_i, addr_last_i, in_range} into the in-flight stage.
REQ-027 In the cycle inflight=1 SHALL push {id, last, data, resp} into the buffer: data = sram_rdata_i, resp = 2'b00 if in_range else data = 0, resp = 2'b10 (SLVERR).
REQ-028 Buffer SHALL be FIFO order; rvalid_o = (count != 0); rid_o/rdata_o/rresp_o/rlast_o SHALL come from the head entry and stay stable while rvalid_o & ~rready_i.
REQ-029 Pop on rvalid_o & rready_i; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-030 Latency: handshake in cycle N -> beat visible on R channel in cycle N+2 when buffer empty.
REQ-031 With DEPTH >= 3 and rready_i held high SHALL sustain one beat per cycle.
REQ-032 Full: no handshake while count + inflight = DEPTH; no push is ever dropped (push with count = DEPTH is impossible by REQ-022).
REQ-033 Pointers SHALL wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-034 rlast_o SHALL equal the addr_last_i captured for that beat; no internal burst counting.

Reset
REQ-035 While areset_i high at a clock edge: count = 0, inflight = 0, pointers = 0; addr_ready_o = 1, rvalid_o = 0, sram_en_o = 0 (addr_valid_i must be 0 during reset), rlast_o = 0, rresp_o = 0, rid_o = 0, rdata_o = 0.
REQ-036 Reset mid-burst SHALL discard buffered and in-flight beats; no R beat issued for them after reset release.

Verification
REQ-037 Single beat: DATA_WIDTH=64, addr_i=0x18, last=1, id=3, SRAM word 3 = 0xA5 -> sram_en_o=1, sram_addr_o=3; two cycles later rvalid_o=1, rdata_o=0xA5, rid_o=3, rlast_o=1, rresp_o=0.
REQ-038 Burst of 8 beats, rready_i=1 throughout, DEPTH=3 -> addr_ready_o never drops, 8 R beats on 8 consecutive cycles, rlast_o only on beat 8.
REQ-039 Backpressure: rready_i=0 for 10 cycles during 8-beat burst -> addr_ready_o low after 3 accepted beats, rdata_o stable, all 8 beats delivered in order once rready_i=1.
REQ-040 Out of range: addr_i=0x8000 (SRAM_AW=12, 64-bit) -> sram_en_o=0, R beat rresp_o=2'b10, rdata_o=0.
REQ-041 Reset with 2 buffered + 1 in-flight beat -> next cycle rvalid_o=0, addr_ready_o=1, no stale beat afterwards.
REQ-042 Simultaneous push/pop at count=DEPTH-1 for 20 cycles with random rready_i -> scoreboard matches SRAM contents and order; pointer wrap exercised with DEPTH=3 and DEPTH=4.

Source files
------------

// File: rtl/sram_rd_pipe.sv
// Converts a stream of per-beat AXI read addresses into SRAM reads. A small
// FIFO holds the returned words so the R channel can apply backpressure.
module sram_rd_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int SRAM_AW    = 12,
  parameter int DEPTH      = 3
) (
  input  logic                  aclk_i,
  input  logic                  areset_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  addr_last_i,
  input  logic                  addr_valid_i,
  output logic                  addr_ready_o,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  sram_en_o,
  output logic [SRAM_AW-1:0]    sram_addr_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i
);

  localparam int OFT = $clog2(DATA_WIDTH / 8);
  localparam int TOP = OFT + SRAM_AW;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [ID_WIDTH-1:0] if_id_q, if_id_d;
  logic            if_last_q, if_last_d;
  logic            if_inr_q, if_inr_d;

  logic            in_range;
  logic            handshake;
  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;
  entry_t          push_entry;
  entry_t          head;
  logic            unused_addr_lo;

  // Byte-lane bits select nothing: narrow beats get the whole word.
  assign unused_addr_lo = ^addr_i[OFT-1:0];

  generate
    if (ADDR_WIDTH > TOP) begin : g_range_chk
      assign in_range = ~|addr_i[ADDR_WIDTH-1:TOP];
    end else begin : g_range_all
      assign in_range = 1'b1;
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready counts the in-flight read so a returning word always has a slot.
  assign occupancy    = {1'b0, count_q} + (CW + 1)'(inflight_q);
  assign addr_ready_o = occupancy < (CW + 1)'(DEPTH);
  assign handshake    = addr_valid_i & addr_ready_o;
  assign sram_en_o    = handshake & in_range;
  assign sram_addr_o  = addr_i[TOP-1:OFT];

  assign push     = inflight_q;
  assign rvalid_o = (count_q != '0);
  assign pop      = rvalid_o & rready_i;
  assign head     = mem_q[rd_ptr_q];

  assign rid_o   = rvalid_o ? head.id   : '0;
  assign rdata_o = rvalid_o ? head.data : '0;
  assign rresp_o = rvalid_o ? head.resp : '0;
  assign rlast_o = rvalid_o ? head.last : 1'b0;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through it can leave a value unassigned and infer a latch.
  always_comb begin
    push_entry.id   = if_id_q;
    push_entry.last = if_last_q;
    push_entry.data = if_inr_q ? sram_rdata_i : '0;
    push_entry.resp = if_inr_q ? RESP_OKAY : RESP_SLVERR;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
    end

    inflight_d = handshake;
    if_id_d    = handshake ? id_i        : if_id_q;
    if_last_d  = handshake ? addr_last_i : if_last_q;
    if_inr_d   = handshake ? in_range    : if_inr_q;

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      if_id_q    <= '0;
      if_last_q  <= 1'b0;
      if_inr_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if_id_q    <= if_id_d;
      if_last_q  <= if_last_d;
      if_inr_q   <= if_inr_d;
    end
  end

  // NOTE: the buffer storage is deliberately not reset; count_q gates every
  // read of it and the R outputs are forced to zero while it is empty.
  always_ff @(posedge aclk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sram_rd_pipe.sv
// Bench for sram_rd_pipe: DEPTH=3 and DEPTH=4 instances share stimulus, each
// tracked by a transaction-level scoreboard, plus directed vector tables.
module tb_sram_rd_pipe;

  logic        aclk_i = 1'b0;
  logic        areset_i;
  logic [31:0] addr_i;
  logic        addr_last_i;
  logic        addr_valid_i;
  logic [3:0]  id_i;
  logic        rready_i;

  logic        rdy_w    [2];
  logic        en_w     [2];
  logic [11:0] saddr_w  [2];
  logic [3:0]  rid_w    [2];
  logic [63:0] rdata_w  [2];
  logic [1:0]  rresp_w  [2];
  logic        rlast_w  [2];
  logic        rvalid_w [2];
  logic [63:0] rd0, rd1;

  logic [63:0] sram [4096];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 aclk_i = ~aclk_i;
  always @(posedge aclk_i) cyc <= cyc + 1;

  sram_rd_pipe #(.DEPTH(3)) u_dut3 (
    .aclk_i(aclk_i), .areset_i(areset_i), .addr_i(addr_i), .addr_last_i(addr_last_i),
    .addr_valid_i(addr_valid_i), .addr_ready_o(rdy_w[0]), .id_i(id_i),
    .sram_en_o(en_w[0]), .sram_addr_o(saddr_w[0]), .sram_rdata_i(rd0),
    .rid_o(rid_w[0]), .rdata_o(rdata_w[0]), .rresp_o(rresp_w[0]), .rlast_o(rlast_w[0]),
    .rvalid_o(rvalid_w[0]), .rready_i(rready_i)
  );

  sram_rd_pipe #(.DEPTH(4)) u_dut4 (
    .aclk_i(aclk_i), .areset_i(areset_i), .addr_i(addr_i), .addr_last_i(addr_last_i),
    .addr_valid_i(addr_valid_i), .addr_ready_o(rdy_w[1]), .id_i(id_i),
    .sram_en_o(en_w[1]), .sram_addr_o(saddr_w[1]), .sram_rdata_i(rd1),
    .rid_o(rid_w[1]), .rdata_o(rdata_w[1]), .rresp_o(rresp_w[1]), .rlast_o(rlast_w[1]),
    .rvalid_o(rvalid_w[1]), .rready_i(rready_i)
  );

  // Synchronous-read SRAM, one port per instance.
  always @(posedge aclk_i) begin
    if (en_w[0]) rd0 <= sram[saddr_w[0]];
    if (en_w[1]) rd1 <= sram[saddr_w[1]];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk_i);
    #1;
  endtask

  // Scoreboard: a beat accepted in cycle N is due on R from cycle N+2 and
  // occupies a slot until popped; ready means fewer than DEPTH slots taken.
  typedef struct {
    logic [3:0]  id;
    logic        last;
    logic [63:0] data;
    logic [1:0]  resp;
    int          stamp;
  } exp_t;

  exp_t sb [2][64];
  int   hd [2] = '{0, 0};
  int   tl [2] = '{0, 0};

  function automatic exp_t make_exp(input logic [31:0] a, input logic [3:0] i,
                                    input logic l, input int st);
    exp_t e;
    logic inr;
    inr     = (a >> 15) == 0;
    e.id    = i;
    e.last  = l;
    e.data  = inr ? sram[a[14:3]] : 64'h0;
    e.resp  = inr ? 2'b00 : 2'b10;
    e.stamp = st;
    return e;
  endfunction

  always @(negedge aclk_i) begin
    int   n, dk;
    logic vis, hs, inr;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (areset_i) begin
        hd[k] = 0;
        tl[k] = 0;
      end else begin
        dk = (k == 0) ? 3 : 4;
        n  = tl[k] - hd[k];
        check($sformatf("m%0d_ready", k), rdy_w[k], n < dk);
        e   = sb[k][hd[k] % 64];
        vis = (n > 0) && (cyc >= e.stamp + 2);
        check($sformatf("m%0d_rvalid", k), rvalid_w[k], vis);
        if (vis) begin
          check($sformatf("m%0d_rid", k), rid_w[k], e.id);
          check($sformatf("m%0d_rdata", k), rdata_w[k], e.data);
          check($sformatf("m%0d_rresp", k), rresp_w[k], e.resp);
          check($sformatf("m%0d_rlast", k), rlast_w[k], e.last);
        end
        inr = (addr_i >> 15) == 0;
        hs  = addr_valid_i && (n < dk);
        check($sformatf("m%0d_sram_en", k), en_w[k], hs && inr);
        if (hs && inr) check($sformatf("m%0d_sram_addr", k), saddr_w[k], addr_i[14:3]);
        if (hs) begin
          sb[k][tl[k] % 64] = make_exp(addr_i, id_i, addr_last_i, cyc);
          tl[k]++;
        end
        if (vis && rready_i) hd[k]++;
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic        last;
    logic        en;
    logic [11:0] saddr;
    logic [63:0] data;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold;
    int          b, got;
    logic        acc;

    vecs[0] = '{32'h0000_0018, 4'h3, 1'b1, 1'b1, 12'h003, 64'h0000_0000_0000_00A5, 2'b00};
    vecs[1] = '{32'h0000_8000, 4'h5, 1'b1, 1'b0, 12'h000, 64'h0, 2'b10};
    vecs[2] = '{32'h0000_7FF8, 4'hF, 1'b0, 1'b1, 12'hFFF, 64'h1234_5678_9ABC_DEF0, 2'b00};
    vecs[3] = '{32'h0000_001D, 4'h1, 1'b1, 1'b1, 12'h003, 64'h0000_0000_0000_00A5, 2'b00};
    vecs[4] = '{32'h0000_0010, 4'h7, 1'b0, 1'b1, 12'h002, 64'hDEAD_BEEF_0000_0002, 2'b00};
    vecs[5] = '{32'hFFFF_FFF8, 4'h2, 1'b1, 1'b0, 12'hFFF, 64'h0, 2'b10};

    areset_i = 1'b1; addr_valid_i = 1'b0; addr_i = '0; id_i = '0;
    addr_last_i = 1'b0; rready_i = 1'b0;
    for (int i = 0; i < 4096; i++) sram[i] = {$urandom, $urandom};
    sram[3]      = 64'h0000_0000_0000_00A5;
    sram[2]      = 64'hDEAD_BEEF_0000_0002;
    sram[12'hFFF] = 64'h1234_5678_9ABC_DEF0;

    // Reset values
    step(); step();
    @(negedge aclk_i);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", rdy_w[k], 1'b1);
      check("rst_rvalid", rvalid_w[k], 1'b0);
      check("rst_sram_en", en_w[k], 1'b0);
      check("rst_rlast", rlast_w[k], 1'b0);
      check("rst_rresp", rresp_w[k], 2'b00);
      check("rst_rid", rid_w[k], 4'h0);
      check("rst_rdata", rdata_w[k], 64'h0);
    end
    step();
    areset_i = 1'b0; rready_i = 1'b1;

    // Single-beat vectors: SRAM side in cycle N, R side in cycle N+2
    for (int v = 0; v < 6; v++) begin
      addr_i = vecs[v].addr; id_i = vecs[v].id; addr_last_i = vecs[v].last;
      addr_valid_i = 1'b1;
      @(negedge aclk_i);
      check($sformatf("v%0d_ready", v), rdy_w[0], 1'b1);
      check($sformatf("v%0d_sram_en", v), en_w[0], vecs[v].en);
      check($sformatf("v%0d_sram_addr", v), saddr_w[0], vecs[v].saddr);
      step();
      addr_valid_i = 1'b0;
      @(negedge aclk_i);
      check($sformatf("v%0d_early", v), rvalid_w[0], 1'b0);
      step();
      @(negedge aclk_i);
      check($sformatf("v%0d_rvalid", v), rvalid_w[0], 1'b1);
      check($sformatf("v%0d_rid", v), rid_w[0], vecs[v].id);
      check($sformatf("v%0d_rdata", v), rdata_w[0], vecs[v].data);
      check($sformatf("v%0d_rresp", v), rresp_w[0], vecs[v].resp);
      check($sformatf("v%0d_rlast", v), rlast_w[0], vecs[v].last);
      step();
    end

    // 8-beat burst at full rate
    for (int c = 0; c < 10; c++) begin
      addr_valid_i = (c < 8); addr_i = 32'h200 + 8 * c; addr_last_i = (c == 7); id_i = 4'h9;
      @(negedge aclk_i);
      if (c < 8) check($sformatf("burst_ready%0d", c), rdy_w[0], 1'b1);
      if (c >= 2) begin
        check($sformatf("burst_rvalid%0d", c), rvalid_w[0], 1'b1);
        check($sformatf("burst_rlast%0d", c), rlast_w[0], c == 9);
        check($sformatf("burst_data%0d", c), rdata_w[0], sram[12'h40 + c - 2]);
      end
      step();
    end

    // 8-beat burst under 10 cycles of R backpressure
    b = 0; got = 0; hold = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      rready_i = (c >= 10); addr_valid_i = (b < 8);
      addr_i = 32'h100 + 8 * b; addr_last_i = (b == 7); id_i = 4'h6;
      @(negedge aclk_i);
      if (c == 3) check("bp_ready_low", rdy_w[0], 1'b0);
      if (c == 4) hold = rdata_w[0];
      if (c == 9) check("bp_stable", rdata_w[0], hold);
      if (rvalid_w[0] && rready_i) begin
        check($sformatf("bp_order%0d", got), rdata_w[0], sram[12'h20 + got]);
        check($sformatf("bp_last%0d", got), rlast_w[0], got == 7);
        got++;
      end
      acc = addr_valid_i & rdy_w[0];
      step();
      if (acc) b++;
    end
    check("bp_count", got, 8);
    addr_valid_i = 1'b0; rready_i = 1'b1;
    repeat (8) step();

    // Reset with two buffered beats and one in flight
    rready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      addr_valid_i = 1'b1; addr_i = 32'h300 + 8 * c; addr_last_i = (c == 2); id_i = 4'hA;
      step();
    end
    addr_valid_i = 1'b0; areset_i = 1'b1;
    @(negedge aclk_i);
    check("rst_mid_pre_rvalid", rvalid_w[0], 1'b1);
    check("rst_mid_pre_ready", rdy_w[0], 1'b0);
    step();
    areset_i = 1'b0; rready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk_i);
      check($sformatf("rst_mid_rvalid3_%0d", c), rvalid_w[0], 1'b0);
      check($sformatf("rst_mid_rvalid4_%0d", c), rvalid_w[1], 1'b0);
      if (c == 0) check("rst_mid_ready", rdy_w[0], 1'b1);
      step();
    end

    // Random traffic, mostly near-full with random R backpressure
    for (int c = 0; c < 400; c++) begin
      addr_valid_i = ($urandom_range(0, 3) != 0);
      addr_i = $urandom & 32'h7FFF;
      if ($urandom_range(0, 7) == 0) addr_i = addr_i | (32'h8000 << $urandom_range(0, 16));
      id_i = 4'($urandom);
      addr_last_i = 1'($urandom);
      rready_i = ($urandom_range(0, 3) != 0);
      step();
    end

    addr_valid_i = 1'b0; rready_i = 1'b1;
    repeat (10) step();
    @(negedge aclk_i);
    check("drain3", tl[0] - hd[0], 0);
    check("drain4", tl[1] - hd[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
